// File: rtl/game_io_pkg.sv
// Shared register-map offsets, CTRL bit positions and small helpers for the
// game I/O register block.
package game_io_pkg;

  localparam logic [2:0] OFF_STATUS = 3'd0;
  localparam logic [2:0] OFF_POS    = 3'd1;
  localparam logic [2:0] OFF_DOORS  = 3'd2;
  localparam logic [2:0] OFF_LIVES  = 3'd3;
  localparam logic [2:0] OFF_CTRL   = 3'd4;
  localparam logic [2:0] OFF_ROUND  = 3'd5;

  localparam int CTRL_CLR_STICKY = 0;
  localparam int CTRL_DEC_P1     = 1;
  localparam int CTRL_DEC_P2     = 2;

  typedef logic [1:0] lives_t;
  typedef logic [1:0] door_t;

  // {valid, idx}: valid only when exactly one bit is set
  function automatic logic [2:0] onehot_to_idx(input logic [3:0] v);
    case (v)
      4'b0001: onehot_to_idx = 3'b1_00;
      4'b0010: onehot_to_idx = 3'b1_01;
      4'b0100: onehot_to_idx = 3'b1_10;
      4'b1000: onehot_to_idx = 3'b1_11;
      default: onehot_to_idx = 3'b0_00;
    endcase
  endfunction

endpackage

// File: rtl/switch_debouncer.sv
// Two-flop synchroniser followed by a stability counter; a value is accepted
// once CYCLES consecutive synchronised samples agree.
module switch_debouncer #(
  parameter int WIDTH  = 4,
  parameter int CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] accepted_nxt,
  output logic [WIDTH-1:0] accepted
);

  localparam int CW = $clog2(CYCLES + 1);

  logic [WIDTH-1:0] s1_q, s2_q, cand_q, cand_d, acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    if (s2_q == cand_q) begin
      if (cnt_q != CW'(CYCLES)) cnt_d = cnt_q + 1'b1;
    end else begin
      cand_d = s2_q;
      cnt_d  = CW'(1);
    end
    // accept on the same edge the CYCLES-th equal sample arrives
    acc_d = (cnt_d == CW'(CYCLES)) ? cand_d : acc_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q   <= '0;
      s2_q   <= '0;
      cand_q <= '0;
      cnt_q  <= '0;
      acc_q  <= '0;
    end else begin
      s1_q   <= din;
      s2_q   <= s1_q;
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
    end
  end

  assign accepted_nxt = acc_d;
  assign accepted     = acc_q;

endmodule

// File: rtl/game_io_regs.sv
// Memory-mapped game-state registers, switch debouncing and round timer.
// Optional macro AUTO_JUDGE_EN: deduct a life from wrong/invalid players on time_up rise.
module game_io_regs
  import game_io_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0400,
  parameter int          DEBOUNCE_CYCLES = 16,
  parameter int          MAX_LIVES       = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic [31:0] rdata,
  input  logic [3:0]  sw_p1,
  input  logic [3:0]  sw_p2,
  input  logic        time_up,
  output logic [1:0]  pos_j1,
  output logic [1:0]  pos_j2,
  output logic [1:0]  correct_door_1,
  output logic [1:0]  correct_door_2,
  output logic [1:0]  p1_lives,
  output logic [1:0]  p2_lives,
  output logic        round_irq
);

  localparam lives_t MAX_L = lives_t'(MAX_LIVES);

  function automatic lives_t sat_lives(input logic [1:0] v);
    sat_lives = (v > MAX_L) ? MAX_L : v;
  endfunction

  logic [3:0] acc1_nxt, acc1, acc2_nxt, acc2;

  switch_debouncer #(.WIDTH(4), .CYCLES(DEBOUNCE_CYCLES)) u_db_p1 (
    .clk(clk), .reset(reset), .din(sw_p1), .accepted_nxt(acc1_nxt), .accepted(acc1));
  switch_debouncer #(.WIDTH(4), .CYCLES(DEBOUNCE_CYCLES)) u_db_p2 (
    .clk(clk), .reset(reset), .din(sw_p2), .accepted_nxt(acc2_nxt), .accepted(acc2));

  logic [31:0] rdata_q, rdata_d;
  door_t       pos_j1_q, pos_j1_d, pos_j2_q, pos_j2_d;
  logic        p1_valid_q, p1_valid_d, p2_valid_q, p2_valid_d;
  logic [3:0]  doors_q, doors_d;
  lives_t      p1_lives_q, p1_lives_d, p2_lives_q, p2_lives_d;
  logic        sticky_q, sticky_d;
  logic [7:0]  round_q, round_d;
  logic        round_irq_q, round_irq_d;
  logic        time_up_q;

  logic       hit, wr, ctrl_wr, rise, dec1, dec2;
  logic [2:0] off, j1, j2;
  logic       unused_bits;

  assign unused_bits = ^{addr[1:0], wdata[31:4]};

  always_comb begin
    hit     = (addr[31:5] == BASE_ADDR[31:5]);
    off     = addr[4:2];
    wr      = we & hit;
    ctrl_wr = wr && (off == OFF_CTRL);
    rise    = time_up & ~time_up_q;

    j1         = onehot_to_idx(acc1_nxt);
    j2         = onehot_to_idx(acc2_nxt);
    p1_valid_d = j1[2];
    p2_valid_d = j2[2];
    pos_j1_d   = j1[2] ? j1[1:0] : pos_j1_q;
    pos_j2_d   = j2[2] ? j2[1:0] : pos_j2_q;

    doors_d     = (wr && off == OFF_DOORS) ? wdata[3:0] : doors_q;
    // a same-cycle rise beats the clear
    sticky_d    = rise | (sticky_q & ~(ctrl_wr & wdata[CTRL_CLR_STICKY]));
    round_d     = round_q + {7'd0, rise};
    round_irq_d = rise;

    dec1 = ctrl_wr & wdata[CTRL_DEC_P1];
    dec2 = ctrl_wr & wdata[CTRL_DEC_P2];
`ifdef AUTO_JUDGE_EN
    if (rise) begin
      dec1 = dec1 | ~p1_valid_q | (pos_j1_q != doors_q[1:0]);
      dec2 = dec2 | ~p2_valid_q | (pos_j2_q != doors_q[3:2]);
    end
`endif
    p1_lives_d = p1_lives_q;
    p2_lives_d = p2_lives_q;
    if (wr && off == OFF_LIVES) begin
      p1_lives_d = sat_lives(wdata[1:0]);
      p2_lives_d = sat_lives(wdata[3:2]);
    end else begin
      if (dec1 && p1_lives_q != '0) p1_lives_d = p1_lives_q - lives_t'(1);
      if (dec2 && p2_lives_q != '0) p2_lives_d = p2_lives_q - lives_t'(1);
    end

    rdata_d = '0;
    if (hit) begin
      case (off)
        OFF_STATUS: rdata_d = {29'd0, p2_valid_q, p1_valid_q, sticky_q};
        OFF_POS:    rdata_d = {20'd0, acc2, acc1, pos_j2_q, pos_j1_q};
        OFF_DOORS:  rdata_d = {28'd0, doors_q};
        OFF_LIVES:  rdata_d = {28'd0, p2_lives_q, p1_lives_q};
        OFF_ROUND:  rdata_d = {24'd0, round_q};
        default:    rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rdata_q     <= '0;
      pos_j1_q    <= '0;
      pos_j2_q    <= '0;
      p1_valid_q  <= 1'b0;
      p2_valid_q  <= 1'b0;
      doors_q     <= '0;
      p1_lives_q  <= MAX_L;
      p2_lives_q  <= MAX_L;
      sticky_q    <= 1'b0;
      round_q     <= '0;
      round_irq_q <= 1'b0;
      time_up_q   <= 1'b0;
    end else begin
      rdata_q     <= rdata_d;
      pos_j1_q    <= pos_j1_d;
      pos_j2_q    <= pos_j2_d;
      p1_valid_q  <= p1_valid_d;
      p2_valid_q  <= p2_valid_d;
      doors_q     <= doors_d;
      p1_lives_q  <= p1_lives_d;
      p2_lives_q  <= p2_lives_d;
      sticky_q    <= sticky_d;
      round_q     <= round_d;
      round_irq_q <= round_irq_d;
      time_up_q   <= time_up;
    end
  end

  assign rdata          = rdata_q;
  assign pos_j1         = pos_j1_q;
  assign pos_j2         = pos_j2_q;
  assign correct_door_1 = doors_q[1:0];
  assign correct_door_2 = doors_q[3:2];
  assign p1_lives       = p1_lives_q;
  assign p2_lives       = p2_lives_q;
  assign round_irq      = round_irq_q;

endmodule

// File: tb/tb_game_io_regs.sv
// Randomised bench for game_io_regs against a cycle-level behavioural model
// built from sample histories and plain register-map arithmetic.
module tb_game_io_regs;

  localparam logic [31:0] BASE = 32'h0000_0400;
  localparam int DB   = 16;
  localparam int MAXL = 3;
  localparam int HL   = DB + 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic        we = 1'b0;
  logic [3:0]  sw_p1 = '0, sw_p2 = '0;
  logic        time_up = 1'b0;
  logic [31:0] rdata;
  logic [1:0]  pos_j1, pos_j2, correct_door_1, correct_door_2, p1_lives, p2_lives;
  logic        round_irq;

  game_io_regs #(.BASE_ADDR(BASE), .DEBOUNCE_CYCLES(DB), .MAX_LIVES(MAXL)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .we(we), .rdata(rdata),
    .sw_p1(sw_p1), .sw_p2(sw_p2), .time_up(time_up),
    .pos_j1(pos_j1), .pos_j2(pos_j2),
    .correct_door_1(correct_door_1), .correct_door_2(correct_door_2),
    .p1_lives(p1_lives), .p2_lives(p2_lives), .round_irq(round_irq));

  always #5 clk = ~clk;

  int vecs = 0, errs = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // behavioural model state; h*[k] is the switch sample taken k edges ago
  typedef logic [3:0] hist_t [HL];
  hist_t      h1, h2;
  logic [3:0] m_acc1, m_acc2, m_doors;
  logic [1:0] m_pos1, m_pos2;
  int         m_l1, m_l2;
  logic       m_v1, m_v2, m_sticky, m_irq, m_tu;
  int         m_round;
  logic [31:0] m_rd;

  function automatic logic [3:0] accept(input hist_t h, input logic [3:0] cur);
    for (int i = 3; i < HL; i++) if (h[i] != h[2]) return cur;
    return h[2];
  endfunction

  function automatic int bit_count(input logic [3:0] v);
    int n = 0;
    for (int i = 0; i < 4; i++) n += v[i];
    return n;
  endfunction

  function automatic int bit_pos(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic int sat(input int v);
    return (v > MAXL) ? MAXL : v;
  endfunction

  task automatic model();
    int off; bit hit, wr, rise, d1, d2;
    if (!reset) begin
      for (int i = 0; i < HL; i++) begin h1[i] = '0; h2[i] = '0; end
      m_acc1 = 0; m_acc2 = 0; m_pos1 = 0; m_pos2 = 0; m_v1 = 0; m_v2 = 0;
      m_doors = 0; m_l1 = MAXL; m_l2 = MAXL; m_sticky = 0; m_round = 0;
      m_irq = 0; m_tu = 0; m_rd = 0;
      return;
    end
    hit = (addr >= BASE) && (addr < BASE + 32);
    off = int'((addr - BASE) / 4);
    wr  = we && hit;
    m_rd = 0;
    if (hit)
      case (off)
        0: m_rd = {29'd0, m_v2, m_v1, m_sticky};
        1: m_rd = {20'd0, m_acc2, m_acc1, m_pos2, m_pos1};
        2: m_rd = {28'd0, m_doors};
        3: m_rd = 32'(m_l2 * 4 + m_l1);
        5: m_rd = 32'(m_round);
        default: m_rd = 0;
      endcase
    rise = time_up && !m_tu;
    m_tu = time_up;
    d1 = wr && off == 4 && wdata[1];
    d2 = wr && off == 4 && wdata[2];
`ifdef AUTO_JUDGE_EN
    if (rise) begin
      if (!m_v1 || m_pos1 != m_doors[1:0]) d1 = 1;
      if (!m_v2 || m_pos2 != m_doors[3:2]) d2 = 1;
    end
`endif
    if (wr && off == 3) begin
      m_l1 = sat(int'(wdata[1:0])); m_l2 = sat(int'(wdata[3:2]));
    end else begin
      if (d1 && m_l1 > 0) m_l1--;
      if (d2 && m_l2 > 0) m_l2--;
    end
    if (wr && off == 2) m_doors = wdata[3:0];
    if (rise) m_sticky = 1;
    else if (wr && off == 4 && wdata[0]) m_sticky = 0;
    if (rise) m_round = (m_round + 1) % 256;
    m_irq = rise;
    for (int i = HL - 1; i > 0; i--) begin h1[i] = h1[i-1]; h2[i] = h2[i-1]; end
    h1[0] = sw_p1; h2[0] = sw_p2;
    m_acc1 = accept(h1, m_acc1);
    m_acc2 = accept(h2, m_acc2);
    m_v1 = (bit_count(m_acc1) == 1); if (m_v1) m_pos1 = 2'(bit_pos(m_acc1));
    m_v2 = (bit_count(m_acc2) == 1); if (m_v2) m_pos2 = 2'(bit_pos(m_acc2));
  endtask

  task automatic tick();
    @(posedge clk); #1;
    model();
    chk("rdata", rdata, m_rd);
    chk("pos", {28'd0, pos_j2, pos_j1}, {28'd0, m_pos2, m_pos1});
    chk("state", {23'd0, correct_door_2, correct_door_1, p2_lives, p1_lives, round_irq},
        {23'd0, m_doors, 2'(m_l2), 2'(m_l1), m_irq});
  endtask

  task automatic store(input logic [7:0] off, input logic [31:0] d);
    addr = BASE + 32'(off); wdata = d; we = 1'b1;
    tick();
    we = 1'b0; addr = '0;
  endtask

  task automatic load(input logic [7:0] off);
    addr = BASE + 32'(off);
    tick();
    addr = '0;
  endtask

  int irq_cnt;

  initial begin
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    chk("rst_lives", {28'd0, p2_lives, p1_lives}, 32'hF);
    chk("rst_pos", {28'd0, pos_j2, pos_j1}, 32'h0);
    load(8'h0C);
    chk("rd_lives", rdata, 32'h0000_000F);

    // debounce latency: accepted exactly 18 edges after the change
    sw_p1 = 4'b0100;
    repeat (17) tick();
    chk("pos_early", {30'd0, pos_j1}, 32'd0);
    tick();
    chk("pos_on_time", {30'd0, pos_j1}, 32'd2);
    load(8'h00);
    chk("p1_valid", {31'd0, rdata[1]}, 32'd1);

    sw_p1 = 4'b0110;
    repeat (25) tick();
    chk("pos_hold_2hot", {30'd0, pos_j1}, 32'd2);
    load(8'h00);
    chk("p1_invalid", {31'd0, rdata[1]}, 32'd0);
    sw_p1 = 4'b0100;
    repeat (20) tick();
    sw_p1 = 4'b0001;
    repeat (5) tick();
    sw_p1 = 4'b0100;
    repeat (25) tick();
    chk("pos_glitch", {30'd0, pos_j1}, 32'd2);

    store(8'h08, 32'h0000_0009);
    chk("doors", {28'd0, correct_door_2, correct_door_1}, 32'h9);
    store(8'h0C, 32'h0000_000F);
    chk("lives_sat", {28'd0, p2_lives, p1_lives}, 32'hF);
    for (int k = 0; k < 4; k++) begin
      store(8'h10, 32'h6);
      chk("lives_dec", {28'd0, p2_lives, p1_lives},
          32'(((2 - k < 0) ? 0 : 2 - k) * 5));
    end

    irq_cnt = 0;
    for (int k = 0; k < 256; k++) begin
      time_up = 1'b1; tick(); irq_cnt += int'(round_irq);
      time_up = 1'b0; tick(); irq_cnt += int'(round_irq);
    end
    chk("irq_cnt", 32'(irq_cnt), 32'd256);
    load(8'h14);
    chk("round_wrap", rdata, 32'd0);

    store(8'h10, 32'h1);
    load(8'h00);
    chk("sticky_clr", {31'd0, rdata[0]}, 32'd0);
    time_up = 1'b1;
    store(8'h10, 32'h1);
    load(8'h00);
    chk("sticky_set_wins", {31'd0, rdata[0]}, 32'd1);
    time_up = 1'b0;
    tick();

`ifdef AUTO_JUDGE_EN
    store(8'h08, 32'h5);
    sw_p1 = 4'b0010; sw_p2 = 4'b1000;
    repeat (20) tick();
    store(8'h0C, 32'hF);
    time_up = 1'b1; tick(); time_up = 1'b0;
    chk("judge", {28'd0, p2_lives, p1_lives}, 32'b1011);
`endif

    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 399) != 0);
      if ($urandom_range(0, 7) == 0) addr = $urandom();
      else addr = BASE + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
      we = ($urandom_range(0, 2) == 0);
      wdata = $urandom();
      if ($urandom_range(0, 5) == 0) time_up = ~time_up;
      if ($urandom_range(0, 29) == 0)
        sw_p1 = ($urandom_range(0, 3) != 0) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom());
      if ($urandom_range(0, 29) == 0)
        sw_p2 = ($urandom_range(0, 3) != 0) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom());
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/game_io_regs.md
Name: game_io_regs

Overview:
Memory-mapped game-state register block. It is the responder on the processor data bus: it decodes processor loads and stores, returns read data one cycle later, and holds the game state (player positions, doors, lives, round count). It also synchronises and debounces the player switches and latches the round-timer expiry. Its outputs drive the screen drawer and the pause/resume logic.

Parameters:
BASE_ADDR, 32'h0000_0400, byte address of register offset 0x00
DEBOUNCE_CYCLES, 16, consecutive stable cycles before a switch group is accepted (min 1)
MAX_LIVES, 3, reset and saturation value of each lives counter (must be ≤3)

Ports:
clk  in  1  pixel/system clock; all logic on its rising edge
reset  in  1  synchronous, active-low; low at a rising clk edge resets all state
addr  in  32  processor byte address
wdata  in  32  processor store data
we  in  1  store strobe, one cycle per store
rdata  out  32  registered load data
sw_p1  in  4  player-1 one-hot door switches, asynchronous
sw_p2  in  4  player-2 one-hot door switches, asynchronous
time_up  in  1  level, high while the round timer is expired
pos_j1  out  2  player-1 accepted door index
pos_j2  out  2  player-2 accepted door index
correct_door_1  out  2  DOORS[1:0]
correct_door_2  out  2  DOORS[3:2]
p1_lives  out  2  player-1 lives
p2_lives  out  2  player-2 lives
round_irq  out  1  one-cycle pulse on the time_up rising edge

Behaviour:
- Decode: hit when addr[31:5] == BASE_ADDR[31:5]; offset = addr[4:2]; addr[1:0] ignored. A miss has no write effect; a load that misses returns 0.
- Register map:
  - 0x00 STATUS (RO): bit0 time_up_sticky, bit1 p1_valid, bit2 p2_valid.
  - 0x04 POS (RO): [1:0] pos_j1, [3:2] pos_j2, [7:4] debounced sw_p1, [11:8] debounced sw_p2.
  - 0x08 DOORS (RW): [3:0]; other bits read 0.
  - 0x0C LIVES (RW): [1:0] p1, [3:2] p2. A written field above MAX_LIVES saturates to MAX_LIVES.
  - 0x10 CTRL (WO, reads 0): bit0 clear sticky, bit1 decrement p1 life, bit2 decrement p2 life.
  - 0x14 ROUND (RO): [7:0] round counter.
  - Offsets 0x18–0x1C read 0 and ignore writes.
- Read: rdata is registered every cycle from the current addr, so data for a load is valid in cycle N+1. rdata reflects state before any same-cycle write (read-before-write).
- Switches:
  - 2-flop synchroniser per group, then debounce: a group is accepted after DEBOUNCE_CYCLES consecutive equal synchronised samples.
  - Input change to accepted value takes 2 + DEBOUNCE_CYCLES cycles.
  - Accepted value exactly one-hot → pos updates to the bit index and px_valid = 1.
  - Otherwise px_valid = 0 and pos holds its last value.
- Timer:
  - time_up is registered; rise = time_up & ~time_up_q.
  - On rise: sticky set, round_irq pulses for 1 cycle, ROUND increments with 8-bit wrap (255 → 0).
  - Sticky set and CTRL bit0 clear in the same cycle → set wins.
- Lives:
  - Decrement saturates at 0.
  - Decrement and auto-judge decrement for the same player in the same cycle apply once.
- Reset values: rdata 0, pos 0, valid 0, doors 0, lives MAX_LIVES, sticky 0, ROUND 0, round_irq 0, debouncers cleared to 0.
- Reset asserted mid-stream: the load in flight returns 0; the store in that cycle is dropped.

Optional Feature:
Macro AUTO_JUDGE_EN.
- Defined: on a time_up rise, a player whose valid = 0 or whose pos ≠ their correct_door loses one life (saturating), in the same cycle as the sticky set.
- Not defined: lives change only through LIVES and CTRL writes; no judge logic is built.

Decomposition:
- Package game_io_pkg holds:
  - offset localparams OFF_STATUS … OFF_ROUND;
  - CTRL bit indices;
  - the `lives_t` (2-bit) and `door_t` (2-bit) typedefs;
  - a function `onehot_to_idx` returning {valid, idx}.
- One sub-module, switch_debouncer (parameter WIDTH, CYCLES; synchroniser plus stability counter), instantiated twice.

Test Plan:
- Reset held low 2 cycles, then released → all outputs 0 except lives = 3 and 3; load of 0x0C returns 0x0000_000F in the next cycle.
- sw_p1 = 4'b0100 held 20 cycles → pos_j1 = 2 exactly 18 cycles after the change; STATUS bit1 = 1.
- sw_p1 = 4'b0110, or a 5-cycle glitch → pos_j1 unchanged.
- Store 0x0000_0009 to 0x08 → correct_door_1 = 1, correct_door_2 = 2.
- Store 0xF to 0x0C → lives saturate to 3/3.
- Store 0x6 to 0x10 four times → lives 2, 1, 0, 0.
- time_up rises 256 times → 256 round_irq pulses and ROUND = 0.
- Clear and rise in the same cycle → sticky = 1.
- With AUTO_JUDGE_EN: doors = 1/1, pos_j1 = 1, pos_j2 = 3, time_up rises → p1_lives = 3, p2_lives = 2.
